// File: rtl/symbol_packer_if.sv
// Byte stream interface between the symbol packer and the host-side consumer.
// The packer drives the show-ahead head byte and its valid flag, and the
// consumer answers with ready to take the byte this cycle.
interface symbol_packer_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_out,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/symbol_packer.sv
// Symbol packer: gathers pairs of 4-bit symbols from the luma decoder into bytes,
// delimited by begin/end marker strobes, and queues them in a show-ahead FIFO.
// Per-frame status gives the byte count, a sticky overflow flag and a verdict.
// Optional feature macro: SYMBOL_PACKER_CHECKSUM_EN adds a running XOR over
// every formed byte of the frame and folds it into the frame verdict.
module symbol_packer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clkin,
  input  logic                     rst,
  input  logic [3:0]               sym_in,
  input  logic                     sym_valid,
  input  logic                     sym_start,
  input  logic                     sym_end,
  symbol_packer_if.master          byteIf,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     frame_active,
  output logic                     frame_done,
  output logic [CNT_W-1:0]         frame_bytes,
  output logic                     frame_ok,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic       r_phase;
  logic       w_phaseNext;
  logic [3:0] r_hi;
  logic [3:0] w_hiNext;
  logic       w_push;
  logic [7:0] w_pushData;
  logic       w_startFrame;
  logic       w_closeFrame;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW-1:0] w_rdPtrNext;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_levelAfterPop;
  logic [7:0]    r_byteOut;
  logic [7:0]    w_headNext;
  logic          w_full;
  logic          w_pop;
  logic          w_accept;
  logic          w_drop;

  logic [CNT_W-1:0] r_frameBytes;
  logic             r_overflow;
  logic             w_overflowNext;
  logic             r_frameDone;
  logic             r_frameOk;
  logic             w_okNext;

`ifdef SYMBOL_PACKER_CHECKSUM_EN
  logic [7:0] r_xor;
  logic [7:0] w_xorNext;
`endif

  // Frame state register; reset aborts any open frame without a done pulse.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and nibble pairing: a begin marker wins over everything, and a
  // symbol arriving with the end marker is consumed before the close decides on a pad.
  always_comb begin
    w_nextState  = r_state;
    w_phaseNext  = r_phase;
    w_hiNext     = r_hi;
    w_push       = 1'b0;
    w_pushData   = 8'h00;
    w_startFrame = 1'b0;
    w_closeFrame = 1'b0;
    case (r_state)
      IDLE: begin
        if (sym_start) begin
          w_nextState  = ACTIVE;
          w_startFrame = 1'b1;
          w_phaseNext  = 1'b0;
        end
      end
      ACTIVE: begin
        if (sym_start) begin
          w_startFrame = 1'b1;
          w_phaseNext  = 1'b0;
        end else begin
          if (sym_valid) begin
            if (!r_phase) begin
              w_hiNext    = sym_in;
              w_phaseNext = 1'b1;
            end else begin
              w_push      = 1'b1;
              w_pushData  = {r_hi, sym_in};
              w_phaseNext = 1'b0;
            end
          end
          if (sym_end) begin
            w_nextState  = IDLE;
            w_closeFrame = 1'b1;
            w_phaseNext  = 1'b0;
            if (sym_valid && !r_phase) begin
              w_push     = 1'b1;
              w_pushData = {sym_in, 4'h0};
            end else if (!sym_valid && r_phase) begin
              w_push     = 1'b1;
              w_pushData = {r_hi, 4'h0};
            end
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: a push into a full FIFO only lands when a pop frees a slot
  // in the same cycle, and the registered head byte is chosen one cycle ahead.
  always_comb begin
    w_pop           = (r_level != '0) & byteIf.byte_ready;
    w_full          = (r_level == FULL_LEVEL);
    w_accept        = w_push & (~w_full | w_pop);
    w_drop          = w_push & w_full & ~w_pop;
    w_rdPtrNext     = w_pop ? r_rdPtr + AW'(1) : r_rdPtr;
    w_levelAfterPop = r_level - LW'(w_pop);
    w_headNext      = r_byteOut;
    if (w_levelAfterPop != '0) begin
      w_headNext = r_mem[w_rdPtrNext];
    end else if (w_accept) begin
      w_headNext = w_pushData;
    end
  end

  // Frame verdict as it will stand once this cycle's push or drop is counted.
  always_comb begin
    w_overflowNext = r_overflow | w_drop;
`ifdef SYMBOL_PACKER_CHECKSUM_EN
    w_xorNext = r_xor ^ (w_push ? w_pushData : 8'h00);
    w_okNext  = (w_xorNext == 8'h00) & ~w_overflowNext;
`else
    w_okNext  = ~w_overflowNext;
`endif
  end

  // Byte storage; only accepted pushes are written, so no reset is needed here.
  always_ff @(posedge clkin) begin
    if (!rst && w_accept) begin
      r_mem[r_wrPtr] <= w_pushData;
    end
  end

  // Pointers, level, head byte, pending nibble and per-frame status registers.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_phase      <= 1'b0;
      r_hi         <= 4'h0;
      r_wrPtr      <= '0;
      r_rdPtr      <= '0;
      r_level      <= '0;
      r_byteOut    <= 8'h00;
      r_frameBytes <= '0;
      r_overflow   <= 1'b0;
      r_frameDone  <= 1'b0;
      r_frameOk    <= 1'b0;
    end else begin
      r_phase   <= w_phaseNext;
      r_hi      <= w_hiNext;
      r_rdPtr   <= w_rdPtrNext;
      r_byteOut <= w_headNext;
      r_level   <= r_level + LW'(w_accept) - LW'(w_pop);
      if (w_accept) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_startFrame) begin
        r_frameBytes <= '0;
      end else if (w_accept && !(&r_frameBytes)) begin
        r_frameBytes <= r_frameBytes + CNT_W'(1);
      end
      if (w_startFrame) begin
        r_overflow <= 1'b0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_frameDone <= w_closeFrame;
      if (w_closeFrame) begin
        r_frameOk <= w_okNext;
      end
    end
  end

`ifdef SYMBOL_PACKER_CHECKSUM_EN
  // Running XOR over every formed byte of the frame, dropped ones included.
  always_ff @(posedge clkin) begin
    if (rst || w_startFrame) begin
      r_xor <= 8'h00;
    end else begin
      r_xor <= w_xorNext;
    end
  end
`endif

  assign byteIf.byte_out   = r_byteOut;
  assign byteIf.byte_valid = (r_level != '0);
  assign fifo_level        = r_level;
  assign frame_active      = (r_state == ACTIVE);
  assign frame_done        = r_frameDone;
  assign frame_bytes       = r_frameBytes;
  assign frame_ok          = r_frameOk;
  assign overflow          = r_overflow;

endmodule
